// File: rtl/relogio_hms.sv
// relogio_hms: BCD hh:mm:ss wall clock driven by a 1 Hz enable pulse.
// The time can be set through a validated load handshake. The block also emits
// one-cycle minute, hour and day rollover pulses.
module relogio_hms #(
  parameter bit FORMAT_24H = 1'b1
) (
  input  logic       relogio_clock,
  input  logic       relogio_reset,
  input  logic       relogio_tick_in,
  input  logic       relogio_pause,
  input  logic       relogio_load_valid,
  output logic       relogio_load_ready,
  input  logic [7:0] relogio_load_h,
  input  logic [7:0] relogio_load_m,
  input  logic [7:0] relogio_load_s,
  input  logic       relogio_load_pm,
  output logic       relogio_load_err,
  output logic [7:0] relogio_h,
  output logic [7:0] relogio_m,
  output logic [7:0] relogio_s,
  output logic       relogio_pm,
  output logic       relogio_min_pulse,
  output logic       relogio_hour_pulse,
  output logic       relogio_day_pulse
);

  localparam int unsigned BCD_W = 8;
  localparam int unsigned NIB_W = 4;
  localparam logic [BCD_W-1:0] H_RESET = FORMAT_24H ? 8'h00 : 8'h12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic             r_load_ready;
  logic             r_load_err;
  logic [BCD_W-1:0] r_h;
  logic [BCD_W-1:0] r_m;
  logic [BCD_W-1:0] r_s;
  logic             r_pm;
  logic             r_min_pulse;
  logic             r_hour_pulse;
  logic             r_day_pulse;

  logic [BCD_W-1:0] r_hold_h;
  logic [BCD_W-1:0] r_hold_m;
  logic [BCD_W-1:0] r_hold_s;
  logic             r_hold_pm;
  logic             r_hold_ok;

  logic             w_handshake;
  logic             w_tick_go;
  logic             w_bus_ok;
  logic [BCD_W-1:0] w_s_next;
  logic [BCD_W-1:0] w_m_next;
  logic [BCD_W-1:0] w_h_next;
  logic             w_pm_next;
  logic             w_s_wrap;
  logic             w_m_wrap;
  logic             w_day_wrap;

  // Two-digit BCD increment without range wrap; callers handle their own limits.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] res;
    if (v[3:0] == 4'd9) begin
      res = {NIB_W'(v[7:4] + 4'd1), 4'd0};
    end else begin
      res = {v[7:4], NIB_W'(v[3:0] + 4'd1)};
    end
    return res;
  endfunction

  function automatic logic nib_ok(input logic [NIB_W-1:0] n);
    return (n <= 4'd9);
  endfunction

  // Minutes and seconds: 00..59.
  function automatic logic ms_ok(input logic [BCD_W-1:0] v);
    return nib_ok(v[3:0]) && (v[7:4] <= 4'd5);
  endfunction

  // Hours: 00..23 in 24h mode, 01..12 in 12h mode.
  function automatic logic h_ok(input logic [BCD_W-1:0] v);
    logic res;
    if (!nib_ok(v[3:0]) || !nib_ok(v[7:4])) begin
      res = 1'b0;
    end else if (FORMAT_24H) begin
      res = (v <= 8'h23);
    end else begin
      res = (v >= 8'h01) && (v <= 8'h12);
    end
    return res;
  endfunction

  assign w_handshake = relogio_load_valid && r_load_ready && (r_state == ST_IDLE);
  assign w_tick_go   = relogio_tick_in && !relogio_pause && (r_state == ST_IDLE);
  assign w_bus_ok    = ms_ok(relogio_load_s) && ms_ok(relogio_load_m) && h_ok(relogio_load_h);

  // Next time value and the wrap flags for a one-second advance.
  always_comb begin
    w_s_wrap   = (r_s == 8'h59);
    w_s_next   = w_s_wrap ? 8'h00 : bcd_inc(r_s);
    w_m_wrap   = w_s_wrap && (r_m == 8'h59);
    w_m_next   = r_m;
    w_h_next   = r_h;
    w_pm_next  = r_pm;
    w_day_wrap = 1'b0;
    if (w_s_wrap) begin
      w_m_next = (r_m == 8'h59) ? 8'h00 : bcd_inc(r_m);
    end
    if (w_m_wrap) begin
      if (FORMAT_24H) begin
        if (r_h == 8'h23) begin
          w_h_next   = 8'h00;
          w_day_wrap = 1'b1;
        end else begin
          w_h_next = bcd_inc(r_h);
        end
      end else begin
        if (r_h == 8'h12) begin
          w_h_next = 8'h01;
        end else begin
          w_h_next = bcd_inc(r_h);
          if (r_h == 8'h11) begin
            // 11->12 flips am/pm; leaving pm means a new day starts.
            w_pm_next  = ~r_pm;
            w_day_wrap = r_pm;
          end
        end
      end
    end
  end

  // FSM state register; load_ready is registered from the next state.
  always_ff @(posedge relogio_clock or negedge relogio_reset) begin
    if (!relogio_reset) begin
      r_state      <= ST_IDLE;
      r_load_ready <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_load_ready <= (w_next_state == ST_IDLE);
    end
  end

  // FSM next-state logic for the load handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_handshake) begin
          w_next_state = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_next_state = r_hold_ok ? ST_COMMIT : ST_IDLE;
      end
      ST_COMMIT: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the load bus at the handshake and grade it. The error flag is
  // registered so that it is high during the CHECK cycle.
  always_ff @(posedge relogio_clock or negedge relogio_reset) begin
    if (!relogio_reset) begin
      r_hold_h   <= '0;
      r_hold_m   <= '0;
      r_hold_s   <= '0;
      r_hold_pm  <= 1'b0;
      r_hold_ok  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (w_handshake) begin
        r_hold_h   <= relogio_load_h;
        r_hold_m   <= relogio_load_m;
        r_hold_s   <= relogio_load_s;
        r_hold_pm  <= relogio_load_pm;
        r_hold_ok  <= w_bus_ok;
        r_load_err <= !w_bus_ok;
      end
    end
  end

  // Time registers and rollover pulses. A commit takes priority; ticks only
  // count in IDLE.
  always_ff @(posedge relogio_clock or negedge relogio_reset) begin
    if (!relogio_reset) begin
      r_h          <= H_RESET;
      r_m          <= '0;
      r_s          <= '0;
      r_pm         <= 1'b0;
      r_min_pulse  <= 1'b0;
      r_hour_pulse <= 1'b0;
      r_day_pulse  <= 1'b0;
    end else begin
      r_min_pulse  <= 1'b0;
      r_hour_pulse <= 1'b0;
      r_day_pulse  <= 1'b0;
      if (r_state == ST_COMMIT) begin
        r_h  <= r_hold_h;
        r_m  <= r_hold_m;
        r_s  <= r_hold_s;
        r_pm <= FORMAT_24H ? 1'b0 : r_hold_pm;
      end else if (w_tick_go) begin
        r_h          <= w_h_next;
        r_m          <= w_m_next;
        r_s          <= w_s_next;
        r_pm         <= FORMAT_24H ? 1'b0 : w_pm_next;
        r_min_pulse  <= w_s_wrap;
        r_hour_pulse <= w_m_wrap;
        r_day_pulse  <= w_day_wrap;
      end
    end
  end

  assign relogio_load_ready = r_load_ready;
  assign relogio_load_err   = r_load_err;
  assign relogio_h          = r_h;
  assign relogio_m          = r_m;
  assign relogio_s          = r_s;
  assign relogio_pm         = r_pm;
  assign relogio_min_pulse  = r_min_pulse;
  assign relogio_hour_pulse = r_hour_pulse;
  assign relogio_day_pulse  = r_day_pulse;

endmodule

// File: tb/tb_relogio_hms.sv
// Bench for relogio_hms: one 24h instance (index 0) and one 12h instance (index 1).
module tb_relogio_hms;

  typedef logic [29:0] obs_t;  // {h, m, s, pm, min_p, hour_p, day_p, ready, err}

  typedef struct {
    int         d;
    logic [7:0] lh;
    logic [7:0] lm;
    logic [7:0] ls;
    logic       lpm;
    bit         ok;
    int         nt;
    logic [7:0] eh;
    logic [7:0] em;
    logic [7:0] es;
    logic       epm;
    logic       emin;
    logic       ehour;
    logic       eday;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick  [2];
  logic       pause [2];
  logic       lv    [2];
  logic [7:0] lh    [2];
  logic [7:0] lm    [2];
  logic [7:0] ls    [2];
  logic       lpm   [2];
  logic       ordy  [2];
  logic       oerr  [2];
  logic [7:0] oh    [2];
  logic [7:0] om    [2];
  logic [7:0] os    [2];
  logic       opm   [2];
  logic       omin  [2];
  logic       ohour [2];
  logic       oday  [2];

  logic [7:0] cur_h  [2];
  logic [7:0] cur_m  [2];
  logic [7:0] cur_s  [2];
  logic       cur_pm [2];

  obs_t  exp_q  [$];
  int    dut_q  [$];
  string name_q [$];

  int n_cmp = 0;
  int n_err = 0;

  vec_t vecs [15];

  always #10 clk = ~clk;

  relogio_hms #(.FORMAT_24H(1'b1)) u_dut24 (
    .relogio_clock     (clk),
    .relogio_reset     (rst_n),
    .relogio_tick_in   (tick[0]),
    .relogio_pause     (pause[0]),
    .relogio_load_valid(lv[0]),
    .relogio_load_ready(ordy[0]),
    .relogio_load_h    (lh[0]),
    .relogio_load_m    (lm[0]),
    .relogio_load_s    (ls[0]),
    .relogio_load_pm   (lpm[0]),
    .relogio_load_err  (oerr[0]),
    .relogio_h         (oh[0]),
    .relogio_m         (om[0]),
    .relogio_s         (os[0]),
    .relogio_pm        (opm[0]),
    .relogio_min_pulse (omin[0]),
    .relogio_hour_pulse(ohour[0]),
    .relogio_day_pulse (oday[0])
  );

  relogio_hms #(.FORMAT_24H(1'b0)) u_dut12 (
    .relogio_clock     (clk),
    .relogio_reset     (rst_n),
    .relogio_tick_in   (tick[1]),
    .relogio_pause     (pause[1]),
    .relogio_load_valid(lv[1]),
    .relogio_load_ready(ordy[1]),
    .relogio_load_h    (lh[1]),
    .relogio_load_m    (lm[1]),
    .relogio_load_s    (ls[1]),
    .relogio_load_pm   (lpm[1]),
    .relogio_load_err  (oerr[1]),
    .relogio_h         (oh[1]),
    .relogio_m         (om[1]),
    .relogio_s         (os[1]),
    .relogio_pm        (opm[1]),
    .relogio_min_pulse (omin[1]),
    .relogio_hour_pulse(ohour[1]),
    .relogio_day_pulse (oday[1])
  );

  function automatic obs_t mk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                              input logic pm, input logic mn, input logic hr, input logic dy,
                              input logic rdy, input logic err);
    return {h, m, s, pm, mn, hr, dy, rdy, err};
  endfunction

  function automatic obs_t obs(input int d);
    return {oh[d], om[d], os[d], opm[d], omin[d], ohour[d], oday[d], ordy[d], oerr[d]};
  endfunction

  function automatic string fmt(input obs_t v);
    return $sformatf("%h:%h:%h pm=%b pulses(m,h,d)=%b%b%b ready=%b err=%b",
                     v[29:22], v[21:14], v[13:6], v[5], v[4], v[3], v[2], v[1], v[0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input int d, input obs_t e);
    name_q.push_back(n);
    dut_q.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    string n;
    int    d;
    obs_t  e;
    obs_t  a;
    n = name_q.pop_front();
    d = dut_q.pop_front();
    e = exp_q.pop_front();
    a = obs(d);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s (dut%0d): got %s, expected %s", n, d, fmt(a), fmt(e));
    end
  endtask

  task automatic chk_int(input string n, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  task automatic wait_ready(input int d, input string tag);
    int g = 0;
    while (ordy[d] !== 1'b1 && g < 20) begin
      step();
      g++;
    end
    if (ordy[d] !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_ready_timeout (dut%0d): got ready=%b, expected 1", tag, d, ordy[d]);
    end
  endtask

  // Full handshake: ready drops for CHECK/COMMIT, error only for bad values,
  // new time two cycles after the handshake edge.
  task automatic load_seq(input int d, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s, input logic pm, input bit ok, input string tag);
    wait_ready(d, tag);
    lv[d] = 1'b1; lh[d] = h; lm[d] = m; ls[d] = s; lpm[d] = pm;
    push({tag, "_hs"}, d, mk(cur_h[d], cur_m[d], cur_s[d], cur_pm[d], 1'b0, 1'b0, 1'b0, 1'b0, !ok));
    step();
    lv[d] = 1'b0;
    pop_check();
    if (!ok) begin
      push({tag, "_rej"}, d, mk(cur_h[d], cur_m[d], cur_s[d], cur_pm[d], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      step();
      pop_check();
    end else begin
      push({tag, "_commit"}, d, mk(cur_h[d], cur_m[d], cur_s[d], cur_pm[d], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      step();
      pop_check();
      cur_h[d] = h; cur_m[d] = m; cur_s[d] = s;
      cur_pm[d] = (d == 0) ? 1'b0 : pm;
      push({tag, "_new"}, d, mk(cur_h[d], cur_m[d], cur_s[d], cur_pm[d], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      step();
      pop_check();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int idx;
    int errs;

    // d, load h/m/s/pm, ok, ticks, expected h/m/s/pm, pulses min/hour/day
    vecs[0]  = '{0, 8'h23, 8'h59, 8'h58, 1'b0, 1'b1, 2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{0, 8'h00, 8'h60, 8'h00, 1'b0, 1'b0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'h1A, 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 4, 8'h12, 8'h35, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{0, 8'h09, 8'h59, 8'h59, 1'b0, 1'b1, 1, 8'h10, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{0, 8'h24, 8'h00, 8'h00, 1'b0, 1'b0, 1, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{0, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, 0, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{0, 8'h19, 8'h09, 8'h59, 1'b0, 1'b1, 1, 8'h19, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{0, 8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1, 8'h11, 8'h59, 8'h59, 1'b0, 1'b1, 1, 8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1, 8'h11, 8'h59, 8'h59, 1'b1, 1'b1, 1, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1, 8'h12, 8'h59, 8'h59, 1'b1, 1'b1, 1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1, 8'h13, 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1, 8'h09, 8'h59, 8'h59, 1'b0, 1'b1, 1, 8'h10, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tick[d] = 1'b0; pause[d] = 1'b0; lv[d] = 1'b0;
      lh[d] = 8'h00; lm[d] = 8'h00; ls[d] = 8'h00; lpm[d] = 1'b0;
    end
    cur_h[0] = 8'h00; cur_h[1] = 8'h12;
    for (int d = 0; d < 2; d++) begin
      cur_m[d] = 8'h00; cur_s[d] = 8'h00; cur_pm[d] = 1'b0;
    end

    // Reset state, then ready rises one cycle after release.
    repeat (2) step();
    push("reset24", 0, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    pop_check();
    push("reset12", 1, mk(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    push("release24", 0, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    push("release12", 1, mk(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    pop_check();
    pop_check();

    // 60 consecutive ticks: one minute pulse, after the 60th edge.
    cnt = 0;
    idx = -1;
    push("sixty_ticks", 0, mk(8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tick[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (omin[0] === 1'b1) begin
        cnt++;
        idx = i;
      end
    end
    tick[0] = 1'b0;
    pop_check();
    chk_int("min_pulse_count", cnt, 1);
    chk_int("min_pulse_edge", idx, 59);
    cur_m[0] = 8'h01;

    // Table: load (valid or rejected), then N ticks.
    for (int i = 0; i < 15; i++) begin
      int d;
      d = vecs[i].d;
      load_seq(d, vecs[i].lh, vecs[i].lm, vecs[i].ls, vecs[i].lpm, vecs[i].ok, $sformatf("vec%0d", i));
      push($sformatf("vec%0d_ticks", i), d,
           mk(vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].epm,
              vecs[i].emin, vecs[i].ehour, vecs[i].eday, 1'b1, 1'b0));
      if (vecs[i].nt > 0) begin
        tick[d] = 1'b1;
        repeat (vecs[i].nt) step();
        tick[d] = 1'b0;
      end
      pop_check();
      cur_h[d] = vecs[i].eh; cur_m[d] = vecs[i].em;
      cur_s[d] = vecs[i].es; cur_pm[d] = vecs[i].epm;
    end

    // Pause freezes time but loads still go through.
    pause[0] = 1'b1;
    push("pause_ticks", 0, mk(cur_h[0], cur_m[0], cur_s[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick[0] = 1'b1;
    repeat (10) step();
    tick[0] = 1'b0;
    pop_check();
    load_seq(0, 8'h05, 8'h06, 8'h07, 1'b0, 1'b1, "pause_load");
    pause[0] = 1'b0;

    // Tick on the handshake edge counts; ticks in CHECK/COMMIT are dropped.
    wait_ready(0, "tick_hs");
    lv[0] = 1'b1; lh[0] = 8'h08; lm[0] = 8'h00; ls[0] = 8'h00; tick[0] = 1'b1;
    push("tick_hs_edge", 0, mk(8'h05, 8'h06, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    lv[0] = 1'b0;
    pop_check();
    push("tick_in_check", 0, mk(8'h05, 8'h06, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step();
    pop_check();
    push("tick_in_commit", 0, mk(8'h08, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    pop_check();
    push("tick_after_commit", 0, mk(8'h08, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    step();
    tick[0] = 1'b0;
    pop_check();

    // Asynchronous reset while in CHECK discards the pending load.
    lv[0] = 1'b1; lh[0] = 8'h07; lm[0] = 8'h08; ls[0] = 8'h09;
    step();
    lv[0] = 1'b0;
    #4;
    rst_n = 1'b0;
    #1;
    push("async_rst24", 0, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    pop_check();
    push("async_rst12", 1, mk(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    pop_check();
    #3;
    rst_n = 1'b1;
    errs = 0;
    push("after_rst", 0, mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      step();
      if (oerr[0] !== 1'b0) errs++;
    end
    pop_check();
    chk_int("no_err_after_rst", errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
